// File: rtl/axi2mem_bridge.sv
// AXI4 slave to single-word native memory adapter; one burst in flight, one beat per request.
// Define AXI2MEM_RR_EN for round-robin AW/AR arbitration instead of fixed write priority.
module axi2mem_bridge #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = ADDR_W - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_axi_awid,
  input  logic [ADDR_W-1:0]     i_axi_awaddr,
  input  logic [7:0]            i_axi_awlen,
  input  logic [2:0]            i_axi_awsize,
  input  logic [1:0]            i_axi_awburst,
  input  logic                  i_axi_awlock,
  input  logic [3:0]            i_axi_awcache,
  input  logic [2:0]            i_axi_awprot,
  input  logic [3:0]            i_axi_awqos,
  input  logic                  i_axi_awvalid,
  output logic                  o_axi_awready,
  input  logic [DATA_W-1:0]     i_axi_wdata,
  input  logic [DATA_W/8-1:0]   i_axi_wstrb,
  input  logic                  i_axi_wlast,
  input  logic                  i_axi_wvalid,
  output logic                  o_axi_wready,
  output logic                  o_axi_bid,
  output logic [1:0]            o_axi_bresp,
  output logic                  o_axi_bvalid,
  input  logic                  i_axi_bready,
  input  logic                  i_axi_arid,
  input  logic [ADDR_W-1:0]     i_axi_araddr,
  input  logic [7:0]            i_axi_arlen,
  input  logic [2:0]            i_axi_arsize,
  input  logic [1:0]            i_axi_arburst,
  input  logic                  i_axi_arlock,
  input  logic [3:0]            i_axi_arcache,
  input  logic [2:0]            i_axi_arprot,
  input  logic [3:0]            i_axi_arqos,
  input  logic                  i_axi_arvalid,
  output logic                  o_axi_arready,
  output logic                  o_axi_rid,
  output logic [DATA_W-1:0]     o_axi_rdata,
  output logic [1:0]            o_axi_rresp,
  output logic                  o_axi_rlast,
  output logic                  o_axi_rvalid,
  input  logic                  i_axi_rready,
  output logic                  o_mem_valid,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wstrb,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  input  logic                  i_mem_ready
);

  typedef enum logic [2:0] {
    StIdle, StWrData, StWrMem, StWrResp, StRdMem, StRdData
  } state_e;

  state_e                r_state;
  logic                  r_id;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic                  r_fixed;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [DATA_W/8-1:0]   r_mem_wstrb;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic                  r_mem_valid;

  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_last_beat;
  logic [MEM_ADDR_W-1:0] w_addr_next;
  logic                  w_unused;

`ifdef AXI2MEM_RR_EN
  // Set when the most recent grant went to write; resets to "read" so write wins first.
  logic r_last_wr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_wr <= 1'b0;
    end else if (r_state == StIdle) begin
      if (w_grant_wr) begin
        r_last_wr <= 1'b1;
      end else if (w_grant_rd) begin
        r_last_wr <= 1'b0;
      end
    end
  end

  assign w_grant_wr = i_axi_awvalid && (!i_axi_arvalid || !r_last_wr);
`else
  assign w_grant_wr = i_axi_awvalid;
`endif
  assign w_grant_rd = i_axi_arvalid && !w_grant_wr;

  assign w_last_beat = (r_cnt == r_len);
  assign w_addr_next = r_fixed ? r_addr : r_addr + {{(MEM_ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_id        <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_fixed     <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_wstrb <= '0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_mem_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_grant_wr) begin
            r_id      <= i_axi_awid;
            r_addr    <= i_axi_awaddr[ADDR_W-1:2];
            r_len     <= i_axi_awlen;
            r_fixed   <= (i_axi_awburst == 2'b00);
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_state   <= StWrData;
          end else if (w_grant_rd) begin
            // Memory read is issued alongside arready; araddr is stable until that handshake.
            r_id        <= i_axi_arid;
            r_addr      <= i_axi_araddr[ADDR_W-1:2];
            r_len       <= i_axi_arlen;
            r_fixed     <= (i_axi_arburst == 2'b00);
            r_arready   <= 1'b1;
            r_mem_valid <= 1'b1;
            r_mem_wstrb <= '0;
            r_state     <= StRdMem;
          end
        end
        StWrData: begin
          r_awready <= 1'b0;
          if (i_axi_wvalid) begin
            r_wdata <= i_axi_wdata;
            if (i_axi_wstrb == '0) begin
              if (w_last_beat) begin
                r_wready <= 1'b0;
                r_bvalid <= 1'b1;
                r_state  <= StWrResp;
              end else begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= w_addr_next;
              end
            end else begin
              r_wready    <= 1'b0;
              r_mem_valid <= 1'b1;
              r_mem_wstrb <= i_axi_wstrb;
              r_state     <= StWrMem;
            end
          end
        end
        StWrMem: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_mem_wstrb <= '0;
            if (w_last_beat) begin
              r_bvalid <= 1'b1;
              r_state  <= StWrResp;
            end else begin
              r_cnt    <= r_cnt + 8'd1;
              r_addr   <= w_addr_next;
              r_wready <= 1'b1;
              r_state  <= StWrData;
            end
          end
        end
        StWrResp: begin
          if (i_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        StRdMem: begin
          r_arready <= 1'b0;
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_rdata     <= i_mem_rdata;
            r_rvalid    <= 1'b1;
            r_rlast     <= w_last_beat;
            r_state     <= StRdData;
          end
        end
        StRdData: begin
          if (i_axi_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_state <= StIdle;
            end else begin
              r_cnt       <= r_cnt + 8'd1;
              r_addr      <= w_addr_next;
              r_mem_valid <= 1'b1;
              r_state     <= StRdMem;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_axi_awready = r_awready;
  assign o_axi_wready  = r_wready;
  assign o_axi_bid     = r_id;
  assign o_axi_bresp   = 2'b00;
  assign o_axi_bvalid  = r_bvalid;
  assign o_axi_arready = r_arready;
  assign o_axi_rid     = r_id;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rresp   = 2'b00;
  assign o_axi_rlast   = r_rlast;
  assign o_axi_rvalid  = r_rvalid;
  assign o_mem_valid   = r_mem_valid;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_mem_wstrb   = r_mem_wstrb;

  // Sideband AXI fields have no meaning for a flat word-wide SRAM.
  assign w_unused = ^{i_axi_awsize, i_axi_awlock, i_axi_awcache, i_axi_awprot, i_axi_awqos,
                      i_axi_awaddr[1:0], i_axi_wlast, i_axi_arsize, i_axi_arlock,
                      i_axi_arcache, i_axi_arprot, i_axi_arqos, i_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi2mem_bridge.sv
// Randomised self-checking bench for axi2mem_bridge: queue-based reference model plus SRAM.
// Honours AXI2MEM_RR_EN for the expected collision order.
module tb_axi2mem_bridge;
  localparam int TMO = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        awid, awlock, awvalid, awready;
  logic [29:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bid, bvalid, bready;
  logic [1:0]  bresp;
  logic        arid, arlock, arvalid, arready;
  logic [29:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos;
  logic        rid, rlast, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        mem_valid, mem_ready;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  axi2mem_bridge dut (
    .i_clk(clk), .i_rst(rst),
    .i_axi_awid(awid), .i_axi_awaddr(awaddr), .i_axi_awlen(awlen), .i_axi_awsize(awsize),
    .i_axi_awburst(awburst), .i_axi_awlock(awlock), .i_axi_awcache(awcache),
    .i_axi_awprot(awprot), .i_axi_awqos(awqos), .i_axi_awvalid(awvalid),
    .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wlast(wlast), .i_axi_wvalid(wvalid),
    .o_axi_wready(wready),
    .o_axi_bid(bid), .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
    .i_axi_arid(arid), .i_axi_araddr(araddr), .i_axi_arlen(arlen), .i_axi_arsize(arsize),
    .i_axi_arburst(arburst), .i_axi_arlock(arlock), .i_axi_arcache(arcache),
    .i_axi_arprot(arprot), .i_axi_arqos(arqos), .i_axi_arvalid(arvalid),
    .o_axi_arready(arready),
    .o_axi_rid(rid), .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rlast(rlast),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  typedef struct packed {logic wr; logic [27:0] addr; logic [31:0] data; logic [3:0] strb;} memop_t;
  typedef struct packed {logic id; logic [31:0] data; logic last;} rbeat_t;

  memop_t      exp_mem[$];
  rbeat_t      exp_r[$];
  logic        exp_b[$];
  logic [31:0] ref_mem[logic [27:0]];
  logic [31:0] sram[logic [27:0]];
  logic [31:0] wbuf[256];
  logic [3:0]  sbuf[256];
  logic [31:0] rlog[$];

  int checks = 0, failures = 0;
  int n_mem = 0, n_w = 0, n_b = 0, n_r = 0, n_rlast = 0;
  logic [27:0] last_maddr;
  logic [31:0] last_mdata, last_rdata;
  logic        last_bid;
  memop_t      e_m;
  rbeat_t      e_r;
  logic        e_b;
  logic        prev_rstall = 1'b0, prev_mstall = 1'b0, prev_rlast;
  logic [31:0] prev_rdata;
  logic [27:0] prev_maddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Unwritten words read back as a recognisable address-derived pattern.
  function automatic logic [31:0] peek_ref(input logic [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : {4'hA, a};
  endfunction
  function automatic logic [31:0] peek_sram(input logic [27:0] a);
    return sram.exists(a) ? sram[a] : {4'hA, a};
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic void exp_write(input logic id, input logic [29:0] addr, input int len,
                                    input logic [1:0] burst);
    memop_t m;
    for (int i = 0; i <= len; i++) begin
      m.addr = addr[29:2] + ((burst == 2'b00) ? 28'd0 : 28'(i));
      if (sbuf[i] != 4'h0) begin
        m.wr = 1'b1; m.data = wbuf[i]; m.strb = sbuf[i];
        exp_mem.push_back(m);
        ref_mem[m.addr] = merge(peek_ref(m.addr), wbuf[i], sbuf[i]);
      end
    end
    exp_b.push_back(id);
  endfunction

  function automatic void exp_read(input logic id, input logic [29:0] addr, input int len,
                                   input logic [1:0] burst);
    memop_t m;
    rbeat_t r;
    for (int i = 0; i <= len; i++) begin
      m.wr = 1'b0; m.data = '0; m.strb = '0;
      m.addr = addr[29:2] + ((burst == 2'b00) ? 28'd0 : 28'(i));
      exp_mem.push_back(m);
      r.id = id; r.data = peek_ref(m.addr); r.last = (i == len);
      exp_r.push_back(r);
    end
  endfunction

  function automatic logic hs(input int ch);
    case (ch)
      0: return awvalid && awready;
      1: return wvalid && wready;
      2: return bvalid && bready;
      3: return arvalid && arready;
      default: return rvalid && rready;
    endcase
  endfunction

  // Returns just after the edge on which the handshake completed.
  task automatic wait_hs(input int ch, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!hs(ch) && n < TMO && !rst);
    if (!hs(ch) && !rst) begin
      checks++; failures++;
      $display("FAIL timeout_%s: no handshake after %0d cycles, want handshake", name, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic gap(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic drv_write(input logic id, input logic [29:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    wait_hs(0, "aw"); awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      gap($urandom_range(0, 1));
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == int'(len)); wvalid = 1'b1;
      wait_hs(1, "w"); wvalid = 1'b0;
    end
    gap($urandom_range(0, 2));
    bready = 1'b1; wait_hs(2, "b"); bready = 1'b0;
  endtask

  task automatic drv_read(input logic id, input logic [29:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat, input int stall_n);
    int k, n;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    wait_hs(3, "ar"); arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      k = (i == stall_beat) ? stall_n : $urandom_range(0, 2);
      if (k > 0) begin
        n = 0;
        while (!rvalid && n < TMO) begin @(posedge clk); #1; n++; end
        gap(k);
      end
      rready = 1'b1; wait_hs(4, "r"); rready = 1'b0;
    end
  endtask

  // SRAM responder: commits writes on the completing edge, ready is a one-cycle pulse.
  bit mem_rand = 1'b0;
  initial begin
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_valid && mem_ready && mem_wstrb != 4'h0)
        sram[mem_addr] = merge(peek_sram(mem_addr), mem_wdata, mem_wstrb);
      @(posedge clk); #1;
      if (rst || mem_ready) mem_ready = 1'b0;
      else if (mem_valid && (!mem_rand || $urandom_range(0, 1) == 0)) begin
        mem_ready = 1'b1; mem_rdata = peek_sram(mem_addr);
      end
    end
  end

  // Compare process: every handshake and every stalled output against the model queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_rstall = 1'b0; prev_mstall = 1'b0;
    end else begin
      if (mem_valid && mem_ready) begin
        n_mem++; last_maddr = mem_addr; last_mdata = mem_wdata;
        if (exp_mem.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_unexpected: got request at %0h, want none", mem_addr);
        end else begin
          e_m = exp_mem.pop_front();
          chk("mem_is_write", 64'(mem_wstrb != 4'h0), 64'(e_m.wr));
          chk("mem_addr", 64'(mem_addr), 64'(e_m.addr));
          if (e_m.wr) begin
            chk("mem_wdata", 64'(mem_wdata), 64'(e_m.data));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(e_m.strb));
          end
        end
      end
      if (wvalid && wready) n_w++;
      if (rvalid && rready) begin
        n_r++; rlog.push_back(rdata); last_rdata = rdata;
        if (rlast) n_rlast++;
        if (exp_r.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected: got beat %0h, want none", rdata);
        end else begin
          e_r = exp_r.pop_front();
          chk("rdata", 64'(rdata), 64'(e_r.data));
          chk("rid", 64'(rid), 64'(e_r.id));
          chk("rlast", 64'(rlast), 64'(e_r.last));
          chk("rresp", 64'(rresp), 64'd0);
        end
      end
      if (bvalid && bready) begin
        n_b++; last_bid = bid;
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected: got bid %0h, want none", bid);
        end else begin
          e_b = exp_b.pop_front();
          chk("bid", 64'(bid), 64'(e_b));
          chk("bresp", 64'(bresp), 64'd0);
        end
      end
      if (prev_rstall) begin
        chk("r_hold_valid", 64'(rvalid), 64'd1);
        chk("r_hold_data", 64'(rdata), 64'(prev_rdata));
        chk("r_hold_last", 64'(rlast), 64'(prev_rlast));
      end
      prev_rstall = rvalid && !rready; prev_rdata = rdata; prev_rlast = rlast;
      if (prev_mstall) begin
        chk("mem_hold_valid", 64'(mem_valid), 64'd1);
        chk("mem_hold_addr", 64'(mem_addr), 64'(prev_maddr));
      end
      prev_mstall = mem_valid && !mem_ready; prev_maddr = mem_addr;
    end
  end

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({awready, wready, bvalid, arready, rvalid, rlast, mem_valid,
                             bid, rid, bresp, rresp}), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
    chk({tag, "_mem"}, 64'({mem_addr, mem_wstrb}), 64'd0);
    chk({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog");
  end

  int          m0, w0, b0, rl0, k, n;
  logic [29:0] a;
  logic [7:0]  len;
  logic [1:0]  burst;
  logic        id;

  initial begin
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready, rready} = '0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid} = '0;
    rst = 1'b1;
    gap(3);
    chk_outs_zero("reset");
    rst = 1'b0;
    gap(1);

    // Single write
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    exp_write(1'b1, 30'h100, 0, 2'b01);
    drv_write(1'b1, 30'h100, 8'd0, 2'b01);
    chk("wr1_addr", 64'(last_maddr), 64'h40);
    chk("wr1_data", 64'(last_mdata), 64'hDEADBEEF);
    chk("wr1_bid", 64'(last_bid), 64'd1);
    chk("wr1_sram", 64'(peek_sram(28'h40)), 64'hDEADBEEF);

    // 16-beat INCR read over word i = i, beat 3 stalled 5 cycles
    for (int i = 0; i < 16; i++) begin
      ref_mem[28'h80 + 28'(i)] = 32'(i); sram[28'h80 + 28'(i)] = 32'(i);
    end
    rlog.delete(); rl0 = n_rlast;
    exp_read(1'b0, 30'h200, 15, 2'b01);
    drv_read(1'b0, 30'h200, 8'd15, 2'b01, 2, 5);
    chk("rd16_count", 64'(rlog.size()), 64'd16);
    chk("rd16_beat0", 64'(rlog[0]), 64'd0);
    chk("rd16_beat2", 64'(rlog[2]), 64'd2);
    chk("rd16_beat15", 64'(rlog[15]), 64'd15);
    chk("rd16_nlast", 64'(n_rlast - rl0), 64'd1);

    // Collision 1: previous grant was a read, so write goes first in both arbitration modes
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    exp_write(1'b1, 30'h300, 0, 2'b01);
    exp_read(1'b0, 30'h300, 0, 2'b01);
    fork
      drv_write(1'b1, 30'h300, 8'd0, 2'b01);
      drv_read(1'b0, 30'h300, 8'd0, 2'b01, -1, 0);
    join
    chk("coll1_rdata", 64'(last_rdata), 64'h12345678);

    // Plain write so the last grant is a write before collision 2
    wbuf[0] = 32'hCAFE0001; sbuf[0] = 4'hF;
    exp_write(1'b0, 30'h400, 0, 2'b01);
    drv_write(1'b0, 30'h400, 8'd0, 2'b01);

    wbuf[0] = 32'h55AA55AA; sbuf[0] = 4'hF;
`ifdef AXI2MEM_RR_EN
    exp_read(1'b0, 30'h500, 0, 2'b01);
    exp_write(1'b1, 30'h500, 0, 2'b01);
`else
    exp_write(1'b1, 30'h500, 0, 2'b01);
    exp_read(1'b0, 30'h500, 0, 2'b01);
`endif
    fork
      drv_write(1'b1, 30'h500, 8'd0, 2'b01);
      drv_read(1'b0, 30'h500, 8'd0, 2'b01, -1, 0);
    join
`ifdef AXI2MEM_RR_EN
    chk("coll2_rdata", 64'(last_rdata), 64'hA000_0140);
`else
    chk("coll2_rdata", 64'(last_rdata), 64'h55AA55AA);
`endif

    // FIXED burst: four writes to one word
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    m0 = n_mem;
    exp_write(1'b0, 30'h600, 3, 2'b00);
    drv_write(1'b0, 30'h600, 8'd3, 2'b00);
    chk("fixed_nmem", 64'(n_mem - m0), 64'd4);
    chk("fixed_addr", 64'(last_maddr), 64'h180);
    chk("fixed_final", 64'(peek_sram(28'h180)), 64'd4);

    // Zero-strobe beat consumes a W beat without a memory request
    wbuf[0] = 32'h11111111; sbuf[0] = 4'h0; wbuf[1] = 32'h22222222; sbuf[1] = 4'hF;
    m0 = n_mem; w0 = n_w; b0 = n_b;
    exp_write(1'b1, 30'h700, 1, 2'b01);
    drv_write(1'b1, 30'h700, 8'd1, 2'b01);
    chk("zstrb_nmem", 64'(n_mem - m0), 64'd1);
    chk("zstrb_nw", 64'(n_w - w0), 64'd2);
    chk("zstrb_nb", 64'(n_b - b0), 64'd1);
    chk("zstrb_word1", 64'(peek_sram(28'h1C1)), 64'h22222222);
    chk("zstrb_word0", 64'(peek_sram(28'h1C0)), 64'hA00001C0);

    // Reset while beat 5 of a 16-beat read is presented
    exp_read(1'b1, 30'h800, 15, 2'b01);
    arid = 1'b1; araddr = 30'h800; arlen = 8'd15; arburst = 2'b01; arvalid = 1'b1;
    wait_hs(3, "ar_rst"); arvalid = 1'b0;
    rready = 1'b1; k = 0; n = 0;
    while (k < 4 && n < TMO) begin @(negedge clk); n++; if (rvalid && rready) k++; end
    @(posedge clk); #1; rready = 1'b0;
    n = 0;
    while (!rvalid && n < TMO) begin @(posedge clk); #1; n++; end
    chk("rst_beat5_valid", 64'(rvalid), 64'd1);
    rst = 1'b1; #1;
    chk_outs_zero("midrst");
    gap(2);
    exp_mem.delete(); exp_r.delete(); exp_b.delete();
    rst = 1'b0;
    gap(1);
    exp_read(1'b0, 30'h100, 0, 2'b01);
    drv_read(1'b0, 30'h100, 8'd0, 2'b01, -1, 0);
    chk("post_rst_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // Random traffic, random memory latency, includes address wrap at the top word
    mem_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFF0 + 30'($urandom_range(0, 3) * 4)
                                      : 30'($urandom_range(0, 255) * 4);
      a[1:0] = 2'($urandom);
      len = 8'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 2));
      id = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(len); i++) begin
          wbuf[i] = $urandom;
          sbuf[i] = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
        end
        exp_write(id, a, int'(len), burst);
        drv_write(id, a, len, burst);
      end else begin
        exp_read(id, a, int'(len), burst);
        drv_read(id, a, len, burst, -1, 0);
      end
    end

    gap(4);
    chk("left_mem", 64'(exp_mem.size()), 64'd0);
    chk("left_r", 64'(exp_r.size()), 64'd0);
    chk("left_b", 64'(exp_b.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
